// File: rtl/memwb_pipe_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | memwb_pipe_reg : parametrised MEM->WB pipeline register with stall/flush,  |
// |                  forwarding port and retired-instruction counter.          |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module memwb_pipe_reg #(
  parameter int DATA_W            = 32,
  parameter int REG_W             = 5,
  parameter int STAGES            = 1,
  parameter int CNT_W             = 32,
  parameter int ZERO_REG_SUPPRESS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stallW,
  input  logic              flushW,
  input  logic              validM,
  input  logic [DATA_W-1:0] aluoutM,
  input  logic [DATA_W-1:0] readdataM,
  input  logic [REG_W-1:0]  writeregM,
  input  logic              regwriteM,
  input  logic              memtoregM,
  output logic [DATA_W-1:0] aluoutW,
  output logic [DATA_W-1:0] readdataW,
  output logic [REG_W-1:0]  writeregW,
  output logic              regwriteW,
  output logic              memtoregW,
  output logic              validW,
  output logic [DATA_W-1:0] resultW,
  output logic              fwd_en,
  output logic [REG_W-1:0]  fwd_reg,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  retired_cnt
);

  localparam int c_LAST = STAGES - 1;
  localparam bit c_ZRS  = (ZERO_REG_SUPPRESS != 0);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] aluout;
    logic [DATA_W-1:0] readdata;
    logic [REG_W-1:0]  writereg;
    logic              regwrite;
    logic              memtoreg;
  } stage_t;

  generate
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
      $error("memwb_pipe_reg: STAGES must be in 1..4");
    end
  endgenerate

  stage_t           r_stage [STAGES];
  stage_t           w_in;
  stage_t           w_last;
  logic [CNT_W-1:0] r_cnt;
  logic             w_regwrite;
  logic             w_zero_blk;
  logic             w_consume;

  // regwrite is qualified at capture so a bubble never carries a write enable
  always_comb begin
    w_in          = '0;
    w_in.valid    = validM;
    w_in.aluout   = aluoutM;
    w_in.readdata = readdataM;
    w_in.writereg = writeregM;
    w_in.regwrite = regwriteM & validM;
    w_in.memtoreg = memtoregM;
  end

  always_ff @(posedge clk) begin
    if (reset || flushW) begin
      r_stage[0] <= '0;
    end else if (!stallW) begin
      r_stage[0] <= w_in;
    end
  end

  generate
    for (genvar g = 1; g < STAGES; g++) begin : g_shift
      always_ff @(posedge clk) begin
        if (reset || flushW) begin
          r_stage[g] <= '0;
        end else if (!stallW) begin
          r_stage[g] <= r_stage[g-1];
        end
      end
    end
  endgenerate

  assign w_last     = r_stage[c_LAST];
  assign w_zero_blk = c_ZRS && (w_last.writereg == '0);
  assign w_regwrite = w_last.regwrite & w_last.valid & ~w_zero_blk;
  // W entry leaves the pipe only on an edge that actually advances it
  assign w_consume  = w_last.valid & ~stallW & ~flushW;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_consume) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign aluoutW     = w_last.aluout;
  assign readdataW   = w_last.readdata;
  assign writeregW   = w_last.writereg;
  assign memtoregW   = w_last.memtoreg;
  assign validW      = w_last.valid;
  assign regwriteW   = w_regwrite;
  assign resultW     = w_last.memtoreg ? w_last.readdata : w_last.aluout;
  assign fwd_en      = w_regwrite;
  assign fwd_reg     = w_last.writereg;
  assign fwd_data    = resultW;
  assign retired_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_memwb_pipe_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_memwb_pipe_reg : bench driving four configurations of memwb_pipe_reg.   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_memwb_pipe_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, stallW, flushW, validM, regwriteM, memtoregM;
  logic [31:0] aluoutM, readdataM;
  logic [4:0]  writeregM;

  logic [31:0] aW [4], rdW [4], resW [4], fdat [4], cntA [4];
  logic [4:0]  wrW [4], freg [4];
  logic        rwW [4], m2rW [4], vW [4], fen [4];

  // dut k: STAGES=k+1; dut1 has zero-reg suppression off; dut3 has a 4-bit counter
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int CW = (g == 3) ? 4 : 32;
    logic [CW-1:0] w_cnt;
    memwb_pipe_reg #(
      .DATA_W(32), .REG_W(5), .STAGES(g + 1), .CNT_W(CW),
      .ZERO_REG_SUPPRESS((g == 1) ? 0 : 1)
    ) u_dut (
      .clk(clk), .reset(reset), .stallW(stallW), .flushW(flushW),
      .validM(validM), .aluoutM(aluoutM), .readdataM(readdataM),
      .writeregM(writeregM), .regwriteM(regwriteM), .memtoregM(memtoregM),
      .aluoutW(aW[g]), .readdataW(rdW[g]), .writeregW(wrW[g]),
      .regwriteW(rwW[g]), .memtoregW(m2rW[g]), .validW(vW[g]),
      .resultW(resW[g]), .fwd_en(fen[g]), .fwd_reg(freg[g]),
      .fwd_data(fdat[g]), .retired_cnt(w_cnt)
    );
    assign cntA[g] = 32'(w_cnt);
  end

  typedef struct packed {
    logic        v;
    logic [31:0] alu;
    logic [31:0] rd;
    logic [4:0]  wr;
    logic        rw;
    logic        m2r;
  } ent_t;

  // Model: each pipe is a delay line of STAGES entries; front is what W shows.
  ent_t        mq [4][$];
  logic [31:0] mcnt [4];
  int          checks = 0;
  int          errors = 0;
  bit          armed  = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (reset || flushW) begin
        mq[k].delete();
        for (int i = 0; i < k + 1; i++) mq[k].push_back('0);
        if (reset) mcnt[k] = 0;
      end else if (!stallW) begin
        if (mq[k][0].v) mcnt[k] = mcnt[k] + 1;
        mq[k].push_back('{v: validM, alu: aluoutM, rd: readdataM, wr: writeregM,
                          rw: regwriteM & validM, m2r: memtoregM});
        void'(mq[k].pop_front());
      end
    end
    if (reset) armed = 1'b1;
  end

  ent_t         ce;
  logic         c_rw;
  logic [31:0]  c_res, c_cnt;
  logic [173:0] c_exp, c_act;

  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < 4; k++) begin
        ce    = mq[k][0];
        c_rw  = ce.rw & ce.v & ((k == 1) || (ce.wr != 5'd0));
        c_res = ce.m2r ? ce.rd : ce.alu;
        c_cnt = (k == 3) ? (mcnt[k] & 32'hF) : mcnt[k];
        c_exp = {ce.v, c_rw, ce.m2r, ce.wr, ce.alu, ce.rd, c_res, c_rw, ce.wr, c_res, c_cnt};
        c_act = {vW[k], rwW[k], m2rW[k], wrW[k], aW[k], rdW[k], resW[k],
                 fen[k], freg[k], fdat[k], cntA[k]};
        checks++;
        if (c_act !== c_exp) begin
          errors++;
          $display("FAIL model_dut%0d t=%0t actual=%h required=%h", k, $time, c_act, c_exp);
        end
      end
    end
  end

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] rd,
                       input logic [4:0] wr, input logic rw, input logic m2r,
                       input logic st, input logic fl, input logic rs);
    validM = v; aluoutM = alu; readdataM = rd; writeregM = wr;
    regwriteM = rw; memtoregM = m2r; stallW = st; flushW = fl; reset = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] alu, input logic [31:0] rd, input logic [4:0] wr,
                       input logic rw, input logic m2r);
    drive(1'b1, alu, rd, wr, rw, m2r, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic bubble();
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    reset = 1'b1; stallW = 1'b0; flushW = 1'b0; validM = 1'b0; regwriteM = 1'b0;
    memtoregM = 1'b0; aluoutM = '0; readdataM = '0; writeregM = '0;

    // single-stage capture and forward
    do_reset(2);
    lit("rst_valid", 32'(vW[0]), 32'd0);
    lit("rst_cnt", cntA[0], 32'd0);
    lit("rst_res_s3", resW[2], 32'd0);
    issue(32'h0000_00A5, 32'h0, 5'd8, 1'b1, 1'b0);
    lit("s1_valid", 32'(vW[0]), 32'd1);
    lit("s1_result", resW[0], 32'h0000_00A5);
    lit("s1_regwrite", 32'(rwW[0]), 32'd1);
    lit("s1_fwd_reg", 32'(freg[0]), 32'd8);
    lit("s1_cnt_before", cntA[0], 32'd0);
    bubble();
    lit("s1_cnt_after", cntA[0], 32'd1);

    // three-stage latency
    do_reset(1);
    issue(32'd1, 32'h0, 5'd1, 1'b1, 1'b0);
    issue(32'd2, 32'h0, 5'd2, 1'b1, 1'b0);
    issue(32'd3, 32'h0, 5'd3, 1'b1, 1'b0);
    lit("s3_w1", aW[2], 32'd1);
    bubble();
    lit("s3_w2", aW[2], 32'd2);
    bubble();
    lit("s3_w3", aW[2], 32'd3);
    lit("s3_cnt2", cntA[2], 32'd2);
    bubble();
    lit("s3_cnt3", cntA[2], 32'd3);

    // stall holds W
    do_reset(1);
    issue(32'h0, 32'hDEAD_BEEF, 5'd3, 1'b1, 1'b1);
    lit("stall_res0", resW[0], 32'hDEAD_BEEF);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'd77, 32'd77, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      lit("stall_res", resW[0], 32'hDEAD_BEEF);
      lit("stall_cnt", cntA[0], 32'd0);
    end
    bubble();
    lit("stall_release_cnt", cntA[0], 32'd1);

    // flush with stall on two stages
    do_reset(1);
    issue(32'd11, 32'h0, 5'd4, 1'b1, 1'b0);
    issue(32'd22, 32'h0, 5'd5, 1'b1, 1'b0);
    lit("flush_pre_valid", 32'(vW[1]), 32'd1);
    drive(1'b1, 32'd99, 32'd0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    lit("flush_valid", 32'(vW[1]), 32'd0);
    lit("flush_rw", 32'(rwW[1]), 32'd0);
    lit("flush_fwd_en", 32'(fen[1]), 32'd0);
    issue(32'd33, 32'h0, 5'd6, 1'b1, 1'b0);
    bubble();
    lit("flush_next_alu", aW[1], 32'd33);
    lit("flush_next_cnt0", cntA[1], 32'd0);
    bubble();
    lit("flush_next_cnt1", cntA[1], 32'd1);

    // register-0 write suppression
    do_reset(1);
    issue(32'd9, 32'h0, 5'd0, 1'b1, 1'b0);
    lit("r0_valid", 32'(vW[0]), 32'd1);
    lit("r0_rw", 32'(rwW[0]), 32'd0);
    lit("r0_fwd_en", 32'(fen[0]), 32'd0);
    bubble();
    lit("r0_cnt", cntA[0], 32'd1);
    lit("r0_nosuppress_rw", 32'(rwW[1]), 32'd1);

    // 4-bit counter wrap on the 4-stage pipe, then reset mid-flight
    do_reset(1);
    for (int i = 1; i <= 17; i++) issue(32'(i), 32'(i * 3), 5'(i % 31 + 1), 1'b1, 1'(i % 2));
    for (int i = 0; i < 4; i++) bubble();
    lit("wrap_cnt", cntA[3], 32'd1);
    for (int i = 0; i < 4; i++) issue(32'(100 + i), 32'd5, 5'd2, 1'b1, 1'b0);
    lit("midrst_pre_valid", 32'(vW[3]), 32'd1);
    do_reset(1);
    lit("midrst_valid", 32'(vW[3]), 32'd0);
    lit("midrst_alu", aW[3], 32'd0);
    lit("midrst_res", resW[3], 32'd0);
    lit("midrst_cnt", cntA[3], 32'd0);

    // mixed traffic against the model
    for (int i = 0; i < 120; i++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom, $urandom, 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 39) == 0));
    end
    bubble();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
